// File: rtl/uart_cmd_pkg.sv
// Shared constants for the UART host-debug command bridge: protocol bytes,
// UART register map defaults, FSM state encoding and reply helpers.
package uart_cmd_pkg;

    localparam logic [7:0] CMD_WR  = 8'h01;
    localparam logic [7:0] CMD_RD  = 8'h02;
    localparam logic [7:0] RSP_WR  = 8'h81;
    localparam logic [7:0] RSP_RD  = 8'h82;
    localparam logic [7:0] RSP_ERR = 8'hEE;

    localparam logic [31:0] DEF_CTRL_INIT        = 32'h0000_0003;
    localparam logic [31:0] DEF_UART_CTRL_ADDR   = 32'h0000_0000;
    localparam logic [31:0] DEF_UART_STATUS_ADDR = 32'h0000_0004;
    localparam logic [31:0] DEF_UART_TXDATA_ADDR = 32'h0000_0008;
    localparam logic [31:0] DEF_UART_RXDATA_ADDR = 32'h0000_000C;
    localparam int unsigned DEF_STATUS_TXFULL_BIT  = 1;
    localparam int unsigned DEF_STATUS_RXEMPTY_BIT = 4;
    localparam int unsigned DEF_TIMEOUT_CYCLES     = 1_000_000;

    typedef enum logic [3:0] {
        ST_INIT     = 4'd0,
        ST_POLL_RX  = 4'd1,
        ST_GET_BYTE = 4'd2,
        ST_PARSE    = 4'd3,
        ST_BUS_REQ  = 4'd4,
        ST_BUS_WAIT = 4'd5,
        ST_POLL_TX  = 4'd6,
        ST_PUT_BYTE = 4'd7
    } state_e;

    function automatic logic [7:0] rsp_code(input logic [7:0] cmd);
        logic [7:0] r;
        case (cmd)
            CMD_WR:  r = RSP_WR;
            CMD_RD:  r = RSP_RD;
            default: r = RSP_ERR;
        endcase
        return r;
    endfunction

    function automatic logic [2:0] rsp_len(input logic [7:0] cmd);
        return (cmd == CMD_RD) ? 3'd5 : 3'd1;
    endfunction

    // Reply byte idx: the code first, then read data little-endian.
    function automatic logic [7:0] rsp_byte(input logic [7:0] cmd, input logic [2:0] idx,
                                            input logic [31:0] rdata);
        logic [7:0] r;
        case (idx)
            3'd0:    r = rsp_code(cmd);
            3'd1:    r = rdata[7:0];
            3'd2:    r = rdata[15:8];
            3'd3:    r = rdata[23:16];
            default: r = rdata[31:24];
        endcase
        return r;
    endfunction

endpackage

// File: rtl/uart_cmd_bridge.sv
// Byte-stream command bridge: polls the UART register port for RX bytes,
// parses read/write word frames, runs them on the system bus and replies via TX.
module uart_cmd_bridge
    import uart_cmd_pkg::*;
#(
    parameter logic [31:0]  CTRL_INIT          = DEF_CTRL_INIT,
    parameter logic [31:0]  UART_CTRL_ADDR     = DEF_UART_CTRL_ADDR,
    parameter logic [31:0]  UART_STATUS_ADDR   = DEF_UART_STATUS_ADDR,
    parameter logic [31:0]  UART_TXDATA_ADDR   = DEF_UART_TXDATA_ADDR,
    parameter logic [31:0]  UART_RXDATA_ADDR   = DEF_UART_RXDATA_ADDR,
    parameter int unsigned  STATUS_TXFULL_BIT  = DEF_STATUS_TXFULL_BIT,
    parameter int unsigned  STATUS_RXEMPTY_BIT = DEF_STATUS_RXEMPTY_BIT,
    parameter int unsigned  TIMEOUT_CYCLES     = DEF_TIMEOUT_CYCLES
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        uart_reg_we_o,
    output logic        uart_reg_re_o,
    output logic [31:0] uart_reg_wdata_o,
    output logic [3:0]  uart_reg_be_o,
    output logic [31:0] uart_reg_addr_o,
    input  logic [31:0] uart_reg_rdata_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_be_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    output logic        busy_o
);

    localparam int unsigned TO_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned TO_W   = (TO_RAW > 20) ? TO_RAW : 20;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_e            state_q, state_d;
    logic              arm_q, arm_d;
    logic              gap_q, gap_d;
    logic [3:0]        byte_cnt_q, byte_cnt_d;
    logic [2:0]        tx_cnt_q, tx_cnt_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [7:0]        rx_byte_q, rx_byte_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;

    logic rx_empty, tx_full;
    logic unused_bits;

    assign rx_empty    = uart_reg_rdata_i[STATUS_RXEMPTY_BIT];
    assign tx_full     = uart_reg_rdata_i[STATUS_TXFULL_BIT];
    assign unused_bits = ^{uart_reg_rdata_i, addr_q[1:0]};

    assign uart_reg_be_o = 4'hF;
    assign bus_be_o      = 4'hF;
    assign bus_req_o     = (state_q == ST_BUS_REQ);
    assign bus_we_o      = (cmd_q == CMD_WR);
    assign bus_addr_o    = {addr_q[31:2], 2'b00};
    assign bus_wdata_o   = wdata_q;
    assign busy_o        = (state_q != ST_POLL_RX) && (state_q != ST_INIT);

    always_comb begin
        state_d    = state_q;
        arm_d      = arm_q;
        gap_d      = gap_q;
        byte_cnt_d = byte_cnt_q;
        tx_cnt_d   = tx_cnt_q;
        cmd_d      = cmd_q;
        rx_byte_d  = rx_byte_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        to_cnt_d   = to_cnt_q;

        uart_reg_we_o    = 1'b0;
        uart_reg_re_o    = 1'b0;
        uart_reg_wdata_o = '0;
        uart_reg_addr_o  = '0;

        case (state_q)
            // arm_q keeps the CTRL strobe off while reset is still asserted.
            ST_INIT: begin
                if (arm_q) begin
                    uart_reg_we_o    = 1'b1;
                    uart_reg_addr_o  = UART_CTRL_ADDR;
                    uart_reg_wdata_o = CTRL_INIT;
                    state_d          = ST_POLL_RX;
                end else begin
                    arm_d = 1'b1;
                end
            end

            ST_POLL_RX: begin
                if (byte_cnt_q != 4'd0) begin
                    if (to_cnt_q == TO_LAST) begin
                        byte_cnt_d = 4'd0;
                        to_cnt_d   = '0;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
                if (gap_q) begin
                    gap_d = 1'b0;
                end else begin
                    uart_reg_re_o   = 1'b1;
                    uart_reg_addr_o = UART_STATUS_ADDR;
                    if (!rx_empty) state_d = ST_GET_BYTE;
                    else           gap_d   = 1'b1;
                end
            end

            ST_GET_BYTE: begin
                uart_reg_re_o   = 1'b1;
                uart_reg_addr_o = UART_RXDATA_ADDR;
                rx_byte_d       = uart_reg_rdata_i[7:0];
                to_cnt_d        = '0;
                state_d         = ST_PARSE;
            end

            // Address and data arrive LSB first, so shift in from the top.
            ST_PARSE: begin
                state_d = ST_POLL_RX;
                if (byte_cnt_q == 4'd0) begin
                    cmd_d = rx_byte_q;
                    if (rx_byte_q == CMD_WR || rx_byte_q == CMD_RD) byte_cnt_d = 4'd1;
                    else                                            state_d    = ST_POLL_TX;
                end else if (byte_cnt_q <= 4'd4) begin
                    addr_d     = {rx_byte_q, addr_q[31:8]};
                    byte_cnt_d = byte_cnt_q + 4'd1;
                    if (byte_cnt_q == 4'd4 && cmd_q == CMD_RD) state_d = ST_BUS_REQ;
                end else begin
                    wdata_d    = {rx_byte_q, wdata_q[31:8]};
                    byte_cnt_d = byte_cnt_q + 4'd1;
                    if (byte_cnt_q == 4'd8) state_d = ST_BUS_REQ;
                end
            end

            ST_BUS_REQ: begin
                if (bus_gnt_i) begin
                    if (bus_rvalid_i) begin
                        rdata_d = bus_rdata_i;
                        state_d = ST_POLL_TX;
                    end else begin
                        state_d = ST_BUS_WAIT;
                    end
                end
            end

            ST_BUS_WAIT: begin
                if (bus_rvalid_i) begin
                    rdata_d = bus_rdata_i;
                    state_d = ST_POLL_TX;
                end
            end

            ST_POLL_TX: begin
                if (gap_q) begin
                    gap_d = 1'b0;
                end else begin
                    uart_reg_re_o   = 1'b1;
                    uart_reg_addr_o = UART_STATUS_ADDR;
                    if (!tx_full) state_d = ST_PUT_BYTE;
                    else          gap_d   = 1'b1;
                end
            end

            ST_PUT_BYTE: begin
                uart_reg_we_o    = 1'b1;
                uart_reg_addr_o  = UART_TXDATA_ADDR;
                uart_reg_wdata_o = {24'h0, rsp_byte(cmd_q, tx_cnt_q, rdata_q)};
                tx_cnt_d         = tx_cnt_q + 3'd1;
                state_d          = ST_POLL_TX;
                if (tx_cnt_q + 3'd1 == rsp_len(cmd_q)) begin
                    tx_cnt_d   = 3'd0;
                    byte_cnt_d = 4'd0;
                    state_d    = ST_POLL_RX;
                end
            end

            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_INIT;
            arm_q      <= 1'b0;
            gap_q      <= 1'b0;
            byte_cnt_q <= '0;
            tx_cnt_q   <= '0;
            cmd_q      <= '0;
            rx_byte_q  <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            to_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            arm_q      <= arm_d;
            gap_q      <= gap_d;
            byte_cnt_q <= byte_cnt_d;
            tx_cnt_q   <= tx_cnt_d;
            cmd_q      <= cmd_d;
            rx_byte_q  <= rx_byte_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

endmodule
